vend_change_dispenser: RTL

Sequential change-dispensing and display stage for the vending machine, the parametrised successor to the combinational output logic. On a vend request it latches the inserted credit and subtracts a configurable price, all in farthings. It then pays out the change as timed coin pulses on the Ha'penny and Farthing LEDs, largest coin first, counting the change down on a multi-digit seven-segment display. It sits between the vending FSM (which issues `start` and `credit`) and the board LEDs/HEX displays.

---
 rtl/vend_change_dispenser.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/vend_change_dispenser.sv
//------------------------------------------------------------------------------
// vend_change_dispenser: pays change as timed Ha'penny/Farthing coin pulses
// and shows credit and remaining change on seven-segment displays.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module vend_change_dispenser #(
  parameter int CREDIT_W  = 4,
  parameter int PRICE     = 3,
  parameter int PULSE_LEN = 4,
  parameter int GAP_LEN   = 2,
  parameter int NDIG      = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [CREDIT_W-1:0] credit,
  output logic                busy,
  output logic                done,
  output logic                insufficient,
  output logic                halfp,
  output logic                far,
  output logic [7*NDIG-1:0]   hex_credit,
  output logic [7*NDIG-1:0]   hex_change
);

  localparam int c_MAXL  = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
  localparam int c_CNT_W = $clog2(c_MAXL + 1);

  localparam logic [CREDIT_W-1:0] c_PRICE    = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W-1:0] c_ONE      = CREDIT_W'(1);
  localparam logic [CREDIT_W-1:0] c_TWO      = CREDIT_W'(2);
  localparam logic [c_CNT_W-1:0]  c_PULSE_LAST = c_CNT_W'(PULSE_LEN - 1);
  localparam logic [c_CNT_W-1:0]  c_GAP_LAST   = c_CNT_W'(GAP_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_HALF_ON  = 3'd1,
    S_HALF_GAP = 3'd2,
    S_FAR_ON   = 3'd3,
    S_FAR_GAP  = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [CREDIT_W-1:0] r_rem, w_rem_nxt;
  logic [CREDIT_W-1:0] r_credit_q, w_credit_nxt;
  logic [c_CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic                r_insuff, w_insuff_nxt;
  logic [CREDIT_W-1:0] w_diff;

  // Largest coin first: choose the next coin phase from the change still owed.
  function automatic state_t f_route(input logic [CREDIT_W-1:0] v);
    if (v >= c_TWO)      return S_HALF_ON;
    else if (v == c_ONE) return S_FAR_ON;
    else                 return S_DONE;
  endfunction

  function automatic logic [31:0] f_pow10(input int n);
    logic [31:0] p;
    p = 32'd1;
    for (int k = 0; k < n; k++) p = p * 32'd10;
    return p;
  endfunction

  function automatic logic [6:0] f_seg(input logic [3:0] d);
    case (d)
      4'd0:    return 7'b1000000;
      4'd1:    return 7'b1111001;
      4'd2:    return 7'b0100100;
      4'd3:    return 7'b0110000;
      4'd4:    return 7'b0011001;
      4'd5:    return 7'b0010010;
      4'd6:    return 7'b0000010;
      4'd7:    return 7'b1111000;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  assign w_diff = credit - c_PRICE;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_rem      <= '0;
      r_credit_q <= '0;
      r_cnt      <= '0;
      r_insuff   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_rem      <= w_rem_nxt;
      r_credit_q <= w_credit_nxt;
      r_cnt      <= w_cnt_nxt;
      r_insuff   <= w_insuff_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_rem_nxt    = r_rem;
    w_credit_nxt = r_credit_q;
    w_cnt_nxt    = r_cnt;
    w_insuff_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_credit_nxt = credit;
        w_cnt_nxt    = '0;
        if (start) begin
          if (credit < c_PRICE) begin
            w_insuff_nxt = 1'b1;
          end else begin
            w_rem_nxt   = w_diff;
            w_state_nxt = f_route(w_diff);
          end
        end
      end
      S_HALF_ON: begin
        if (r_cnt == c_PULSE_LAST) begin
          w_cnt_nxt   = '0;
          w_rem_nxt   = r_rem - c_TWO;
          w_state_nxt = S_HALF_GAP;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_HALF_GAP: begin
        if (r_cnt == c_GAP_LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = f_route(r_rem);
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_FAR_ON: begin
        if (r_cnt == c_PULSE_LAST) begin
          w_cnt_nxt   = '0;
          w_rem_nxt   = r_rem - c_ONE;
          w_state_nxt = S_FAR_GAP;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_FAR_GAP: begin
        if (r_cnt == c_GAP_LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_DONE;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign busy         = (r_state != S_IDLE);
  assign done         = (r_state == S_DONE);
  assign halfp        = (r_state == S_HALF_ON);
  assign far          = (r_state == S_FAR_ON);
  assign insufficient = r_insuff;

  // Divisors are elaboration-time constants, so each digit is a small fixed divider.
  for (genvar i = 0; i < NDIG; i++) begin : g_dig
    localparam logic [31:0] c_DIV = f_pow10(i);
    assign hex_credit[7*i +: 7] = f_seg(4'((32'(r_credit_q) / c_DIV) % 32'd10));
    assign hex_change[7*i +: 7] = f_seg(4'((32'(r_rem) / c_DIV) % 32'd10));
  end

endmodule

`default_nettype wire
